usart_tx_arbiter: RTL

- Shares one usart_tx byte channel between NUM_REQ independent requesters, for example the debug console, a monitor and a DMA-fed logger.
- Arbitration is round-robin at message granularity: once a requester is granted, it keeps the transmitter until it sends a byte flagged last, or until it stalls past a timeout.
- Sits between the requesters and the usart_tx data_in/valid/ready handshake.

---
 rtl/usart_tx_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/usart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// usart_tx_arbiter
//
// Shares one usart_tx byte channel between NUM_REQ requesters. Arbitration is
// round-robin at message granularity. A granted requester keeps the channel
// until it transfers a byte flagged last, or until it stalls (valid low) for
// TIMEOUT_CYCLES cycles. A TIMEOUT_CYCLES value of 0 disables the timeout.
//
// Optional feature: define USART_ARB_TAG_EN to emit a channel tag byte
// (TAG_BASE + owner index) ahead of every message, so the receiving host can
// demultiplex the interleaved messages.
//
// Ports:
//   serial_clock  in   block clock, same domain as usart_tx
//   reset         in   asynchronous, active-high reset
//   req_data      in   NUM_REQ bytes; requester i at [i*DATA_BITS +: DATA_BITS]
//   req_valid     in   requester i has a byte
//   req_last      in   requester i's current byte ends its message
//   req_ready     out  requester i's byte is accepted this cycle
//   tx_data       out  byte to usart_tx
//   tx_valid      out  tx_data is valid
//   tx_ready      in   usart_tx accepts the byte
//   grant         out  one-hot channel owner, 0 when idle
//   busy          out  channel owned
//   timeout       out  one-cycle pulse when a grant is revoked by the timeout
// -----------------------------------------------------------------------------
module usart_tx_arbiter #(
  parameter int                   NUM_REQ        = 4,
  parameter int                   DATA_BITS      = 8,
  parameter int                   TIMEOUT_CYCLES = 4095,
  parameter logic [DATA_BITS-1:0] TAG_BASE       = 8'hF0
) (
  input  logic                           serial_clock,
  input  logic                           reset,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           timeout
);

  localparam int         PTR_W       = $clog2(NUM_REQ);
  localparam logic [11:0] TIMEOUT_LIM = 12'(TIMEOUT_CYCLES);

  // TAG is only entered when the tag feature is compiled in; without it the
  // state is unreachable and its logic is trimmed away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [NUM_REQ-1:0] grant_next;
  logic [PTR_W-1:0]   owner, owner_next;   // index of the granted requester
  logic [PTR_W-1:0]   ptr, ptr_next;       // last requester served
  logic [11:0]        stall_cnt, stall_next;
  logic               timeout_next;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand_idx;

  // Round-robin scan starting one past the last served requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    cand_idx   = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // NOTE: every output and next-state variable is given a default before the
  // case statement, so no path through the block leaves one unassigned and
  // no latch is inferred.
  always_comb begin
    state_next   = state;
    grant_next   = grant;
    owner_next   = owner;
    ptr_next     = ptr;
    stall_next   = stall_cnt;
    timeout_next = 1'b0;
    tx_data      = '0;
    tx_valid     = 1'b0;
    req_ready    = '0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
          owner_next           = pick_idx;
          stall_next           = '0;
`ifdef USART_ARB_TAG_EN
          state_next           = TAG;
`else
          state_next           = PASS;
`endif
        end
      end

      TAG: begin
        // Tag byte is generated here; requesters see no ready, and the stall
        // counter is held.
        tx_data  = TAG_BASE + DATA_BITS'(owner);
        tx_valid = 1'b1;
        if (tx_ready) state_next = PASS;
      end

      PASS: begin
        tx_data          = req_data[int'(owner)*DATA_BITS +: DATA_BITS];
        tx_valid         = req_valid[owner];
        req_ready[owner] = tx_ready;
        if (req_valid[owner] && tx_ready) begin
          stall_next = '0;
          if (req_last[owner]) begin
            ptr_next   = owner;
            grant_next = '0;
            state_next = IDLE;
          end
        end else if (!req_valid[owner]) begin
          // Only an absent byte counts as a stall; backpressure from
          // usart_tx never revokes the grant.
          stall_next = stall_cnt + 12'd1;
          if ((TIMEOUT_LIM != 12'd0) && (stall_next == TIMEOUT_LIM)) begin
            timeout_next = 1'b1;
            ptr_next     = owner;
            grant_next   = '0;
            state_next   = IDLE;
          end
        end
      end

      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge serial_clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      ptr       <= PTR_W'(NUM_REQ - 1);
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      owner     <= owner_next;
      ptr       <= ptr_next;
      stall_cnt <= stall_next;
      timeout   <= timeout_next;
    end
  end

  assign busy = |grant;

endmodule
